jedro_1_ifu_prefetch: RTL

Parametrised successor to the single-entry jedro_1 instruction fetch unit. It issues sequential reads to a synchronous instruction ROM with fixed 1-cycle latency and buffers returned words in a FIFO_DEPTH-deep prefetch queue. Each instruction is presented to the decoder with its address over a valid/ready handshake. On a jump it redirects the PC and flushes both the queue and any in-flight read.

---
 rtl/jedro_1_ifu_prefetch.sv | 139 +++++++++++++
 1 files changed

// File: rtl/jedro_1_ifu_prefetch.sv
// jedro_1 instruction fetch unit with a FIFO_DEPTH-deep prefetch queue.
// Issues sequential reads to a 1-cycle-latency instruction ROM, buffers the
// returned words with their addresses, and hands them to the decoder over a
// valid/ready handshake.
//
// Handshake: an instruction transfers in any cycle where instr_valid_o and
// decoder_ready_i are both high; while instr_valid_o is high and
// decoder_ready_i is low, instr_o and instr_addr_o hold their values.
//
// Optional feature macro: JEDRO_1_IFU_MISALIGN_EXC_EN
//   defined   : adds instr_misalign_o; a jump to a non-word-aligned target
//               raises the flag and stops fetching until an aligned jump or
//               reset.
//   undefined : the low two bits of a jump target are cleared before use.
module jedro_1_ifu_prefetch #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  jmp_instr_i,
  input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_valid_o,
  input  logic                  decoder_ready_i
`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
  ,
  output logic                  instr_misalign_o
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Queue storage: instruction word and the address it was fetched from.
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         count;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] req_addr;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  fetch_block;
  logic [CW:0]           credit;
  logic [ADDR_WIDTH-1:0] jmp_target;

`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
  logic misalign_q;
  logic jmp_misaligned;

  assign jmp_misaligned   = (jmp_addr_i[1:0] != 2'b00);
  assign jmp_target       = jmp_addr_i;
  assign fetch_block      = misalign_q;
  assign instr_misalign_o = misalign_q;

  // Misalignment flag: set by a misaligned jump, cleared by an aligned one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (jmp_instr_i) begin
      misalign_q <= jmp_misaligned;
    end
  end
`else
  assign jmp_target  = {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign fetch_block = 1'b0;
`endif

  assign instr_valid_o = (count != '0);
  assign pop           = instr_valid_o & decoder_ready_i;
  // A response lands in the queue unless a jump in the same cycle kills it.
  assign push          = inflight & ~jmp_instr_i;

  // Credit includes the in-flight read, so a full queue can never overflow.
  assign credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue  = ~rst_i & ~jmp_instr_i & ~fetch_block &
                  (credit < (CW+1)'(FIFO_DEPTH));

  assign mem_en_o     = issue;
  assign mem_addr_o   = pc;
  // Head is read straight from storage; forced to zero while empty.
  assign instr_o      = instr_valid_o ? q_data[rptr] : '0;
  assign instr_addr_o = instr_valid_o ? q_addr[rptr] : '0;

  // Fetch PC and in-flight tracking; a jump redirects and cancels the read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc       <= BOOT_ADDR;
      inflight <= 1'b0;
      req_addr <= '0;
    end else begin
      inflight <= issue;
      if (jmp_instr_i) begin
        pc <= jmp_target;
      end else if (issue) begin
        pc       <= pc + ADDR_WIDTH'(4);
        req_addr <= pc;
      end
    end
  end

  // Queue pointers and occupancy; a jump empties the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || jmp_instr_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage write for ROM responses.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      q_data[wptr] <= mem_rdata_i;
      q_addr[wptr] <= req_addr;
    end
  end

endmodule
